// File: rtl/xbar_cell_ctrl.sv
// Crossbar cell controller: converts accepted-grant pulses from the
// scheduler into per-output crossbar selects held for one cell time,
// issues per-input VOQ dequeue commands and reports input/output idle.
module xbar_cell_ctrl #(
  parameter int N        = 12,
  parameter int P        = 8,
  parameter int LOGN     = 4,
  parameter int CELL_LEN = 16,
  parameter int GAP      = 1,
  parameter int CNTW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*N-1:0]    i_acc_grant,
  input  logic [N*P-1:0]    i_acc_priority,
  output logic [N-1:0]      o_input_idle,
  output logic [N-1:0]      o_output_idle,
  output logic [N*LOGN-1:0] o_sel,
  output logic [N-1:0]      o_sel_valid,
  output logic [N-1:0]      o_dequeue,
  output logic [N*LOGN-1:0] o_deq_output,
  output logic [N*P-1:0]    o_deq_priority,
  output logic              o_error
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_GUARD = 2'd2} state_t;

  state_t          state_q   [N];
  logic [CNTW-1:0] cnt_q     [N];
  logic [LOGN-1:0] sel_q     [N];
  logic [N-1:0]    deq_q;
  logic [LOGN-1:0] deq_out_q [N];
  logic [P-1:0]    deq_pri_q [N];
  logic            err_q;

  logic [N-1:0]    in_idle;
  logic [N-1:0]    out_idle;
  logic [N-1:0]    grant_row [N];
  logic [N-1:0]    grant_col [N];
  logic [N-1:0]    acc_row   [N];
  logic [N-1:0]    row_multi;
  logic [N-1:0]    col_multi;
  logic [N-1:0]    row_hit;
  logic [LOGN-1:0] row_idx   [N];
  logic [N-1:0]    col_hit;
  logic [LOGN-1:0] col_idx   [N];
  logic            err_d;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [N-1:0] v);
    return |(v & (v - N'(1)));
  endfunction

  // Idle vectors decoded straight from FSM registers so they track state changes.
  always_comb begin
    in_idle = '1;
    for (int j = 0; j < N; j++) begin
      out_idle[j] = (state_q[j] == S_IDLE);
      for (int i = 0; i < N; i++) begin
        if (state_q[j] != S_IDLE && sel_q[j] == LOGN'(i)) in_idle[i] = 1'b0;
      end
    end
  end

  // Grant validation: drop multi-hot rows/columns and grants to busy ports.
  always_comb begin
    err_d   = 1'b0;
    row_hit = '0;
    col_hit = '0;
    for (int i = 0; i < N; i++) begin
      row_idx[i]   = '0;
      col_idx[i]   = '0;
      acc_row[i]   = '0;
      grant_row[i] = i_acc_grant[i*N +: N];
      for (int j = 0; j < N; j++) grant_col[i][j] = i_acc_grant[j*N + i];
    end
    for (int i = 0; i < N; i++) begin
      row_multi[i] = multi_hot(grant_row[i]);
      col_multi[i] = multi_hot(grant_col[i]);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_row[i][j] = grant_row[i][j] & ~row_multi[i] & ~col_multi[j]
                        & out_idle[j] & in_idle[i];
        if (grant_row[i][j] && !acc_row[i][j]) err_d = 1'b1;
        if (acc_row[i][j]) begin
          row_hit[i] = 1'b1;
          row_idx[i] = LOGN'(j);
          col_hit[j] = 1'b1;
          col_idx[j] = LOGN'(i);
        end
      end
    end
  end

  // Per-output IDLE/XFER/GUARD sequencer with cell-time counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= S_IDLE;
        cnt_q[j]   <= '0;
        sel_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        case (state_q[j])
          S_IDLE: begin
            if (col_hit[j]) begin
              state_q[j] <= S_XFER;
              cnt_q[j]   <= CNTW'(CELL_LEN - 1);
              sel_q[j]   <= col_idx[j];
            end
          end
          S_XFER: begin
            if (cnt_q[j] == '0) begin
              if (GAP > 0) begin
                state_q[j] <= S_GUARD;
                cnt_q[j]   <= CNTW'(GAP - 1);
              end else begin
                state_q[j] <= S_IDLE;
              end
            end else begin
              cnt_q[j] <= cnt_q[j] - CNTW'(1);
            end
          end
          S_GUARD: begin
            if (cnt_q[j] == '0) state_q[j] <= S_IDLE;
            else                cnt_q[j]   <= cnt_q[j] - CNTW'(1);
          end
          default: state_q[j] <= S_IDLE;
        endcase
      end
    end
  end

  // One-cycle dequeue pulse; destination and priority hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      deq_q <= '0;
      for (int i = 0; i < N; i++) begin
        deq_out_q[i] <= '0;
        deq_pri_q[i] <= '0;
      end
    end else begin
      deq_q <= row_hit;
      for (int i = 0; i < N; i++) begin
        if (row_hit[i]) begin
          deq_out_q[i] <= row_idx[i];
          deq_pri_q[i] <= i_acc_priority[i*P +: P];
        end
      end
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (reset)      err_q <= 1'b0;
    else if (err_d) err_q <= 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign o_sel[k*LOGN +: LOGN]       = sel_q[k];
    assign o_sel_valid[k]              = (state_q[k] == S_XFER);
    assign o_deq_output[k*LOGN +: LOGN] = deq_out_q[k];
    assign o_deq_priority[k*P +: P]    = deq_pri_q[k];
  end

  assign o_input_idle  = in_idle;
  assign o_output_idle = out_idle;
  assign o_dequeue     = deq_q;
  assign o_error       = err_q;

endmodule

// File: tb/tb_xbar_cell_ctrl.sv
// Bench for xbar_cell_ctrl: directed grant vectors, dequeue scoreboard
// checked by a monitor, plus cycle-accurate status checks.
module tb_xbar_cell_ctrl;

  localparam int N    = 12;
  localparam int P    = 8;
  localparam int LOGN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*N-1:0]    i_acc_grant;
  logic [N*P-1:0]    i_acc_priority;
  logic [N-1:0]      o_input_idle;
  logic [N-1:0]      o_output_idle;
  logic [N*LOGN-1:0] o_sel;
  logic [N-1:0]      o_sel_valid;
  logic [N-1:0]      o_dequeue;
  logic [N*LOGN-1:0] o_deq_output;
  logic [N*P-1:0]    o_deq_priority;
  logic              o_error;

  typedef struct packed {
    logic [N-1:0]      deq;
    logic [N*LOGN-1:0] outs;
    logic [N*P-1:0]    pris;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  xbar_cell_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_acc_grant    (i_acc_grant),
    .i_acc_priority (i_acc_priority),
    .o_input_idle   (o_input_idle),
    .o_output_idle  (o_output_idle),
    .o_sel          (o_sel),
    .o_sel_valid    (o_sel_valid),
    .o_dequeue      (o_dequeue),
    .o_deq_output   (o_deq_output),
    .o_deq_priority (o_deq_priority),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a grant for one cycle; returns #1 after the edge that samples it.
  task automatic send(input logic [N*N-1:0] g, input logic [N*P-1:0] pr);
    i_acc_grant    = g;
    i_acc_priority = pr;
    step();
    i_acc_grant    = '0;
    i_acc_priority = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every dequeue pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_dequeue !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dequeue", o_dequeue, '0);
        end else begin
          e = exp_q.pop_front();
          check("deq_vector", o_dequeue, e.deq);
          for (int i = 0; i < N; i++) begin
            if (e.deq[i]) begin
              check("deq_output", o_deq_output[i*LOGN +: LOGN], e.outs[i*LOGN +: LOGN]);
              check("deq_priority", o_deq_priority[i*P +: P], e.pris[i*P +: P]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [N*N-1:0]    g;
    logic [N*P-1:0]    pr;
    exp_t              e;
    logic [N*LOGN-1:0] sel_exp;

    reset          = 1'b1;
    i_acc_grant    = '0;
    i_acc_priority = '0;
    step(3);
    reset = 1'b0;

    // Reset then idle for 10 cycles.
    check("rst_deq_output", o_deq_output, '0);
    check("rst_sel", o_sel, '0);
    step(10);
    check("idle_in", o_input_idle, 12'hFFF);
    check("idle_out", o_output_idle, 12'hFFF);
    check("idle_selv", o_sel_valid, '0);
    check("idle_err", o_error, 1'b0);
    check("idle_deq", o_dequeue, '0);

    // Single grant 3 -> 5, priority 0x04; other rows carry ignored priorities.
    g = '0; g[3*N + 5] = 1'b1;
    pr = {N*P/32{32'hDEADBEEF}}; pr[3*P +: P] = 8'h04;
    e = '0; e.deq = 12'h008; e.outs[3*LOGN +: LOGN] = 4'd5; e.pris[3*P +: P] = 8'h04;
    exp_q.push_back(e);
    send(g, pr);
    check("s_selv_t1", o_sel_valid, 12'h020);
    check("s_sel5", o_sel[5*LOGN +: LOGN], 4'd3);
    check("s_in_t1", o_input_idle, 12'hFF7);
    check("s_out_t1", o_output_idle, 12'hFDF);
    step(15);
    check("s_selv_t16", o_sel_valid, 12'h020);
    step();
    check("s_selv_t17", o_sel_valid, '0);
    check("s_in_t17", o_input_idle, 12'hFF7);
    check("s_out_t17", o_output_idle, 12'hFDF);
    step();
    check("s_in_t18", o_input_idle, 12'hFFF);
    check("s_out_t18", o_output_idle, 12'hFFF);

    // Full permutation i -> (i+1) mod N.
    g = '0; pr = '0; e = '0; sel_exp = '0;
    for (int i = 0; i < N; i++) begin
      g[i*N + (i+1) % N] = 1'b1;
      pr[i*P +: P] = P'(8'h30 + i);
      e.outs[i*LOGN +: LOGN] = LOGN'((i+1) % N);
      e.pris[i*P +: P] = P'(8'h30 + i);
      sel_exp[((i+1) % N)*LOGN +: LOGN] = LOGN'(i);
    end
    e.deq = 12'hFFF;
    exp_q.push_back(e);
    send(g, pr);
    check("p_selv_t1", o_sel_valid, 12'hFFF);
    check("p_sel", o_sel, sel_exp);
    step();
    check("p_deq_t2", o_dequeue, '0);
    step(14);
    check("p_selv_t16", o_sel_valid, 12'hFFF);
    step();
    check("p_selv_t17", o_sel_valid, '0);
    check("p_in_t17", o_input_idle, '0);
    step();
    check("p_in_t18", o_input_idle, 12'hFFF);
    check("p_out_t18", o_output_idle, 12'hFFF);
    check("p_err", o_error, 1'b0);

    // Column conflict on output 2 plus a clean (4,7).
    g = '0; g[0*N + 2] = 1'b1; g[1*N + 2] = 1'b1; g[4*N + 7] = 1'b1;
    pr = '0; pr[4*P +: P] = 8'hA5;
    e = '0; e.deq = 12'h010; e.outs[4*LOGN +: LOGN] = 4'd7; e.pris[4*P +: P] = 8'hA5;
    exp_q.push_back(e);
    send(g, pr);
    check("c_err", o_error, 1'b1);
    check("c_selv", o_sel_valid, 12'h080);
    check("c_sel7", o_sel[7*LOGN +: LOGN], 4'd4);
    check("c_in", o_input_idle, 12'hFEF);
    step(17);
    check("c_idle_after", o_output_idle, 12'hFFF);
    check("c_err_sticky", o_error, 1'b1);

    // Grant to an output that is in GUARD.
    do_reset();
    check("b_err_clr", o_error, 1'b0);
    g = '0; g[3*N + 5] = 1'b1;
    pr = '0; pr[3*P +: P] = 8'h11;
    e = '0; e.deq = 12'h008; e.outs[3*LOGN +: LOGN] = 4'd5; e.pris[3*P +: P] = 8'h11;
    exp_q.push_back(e);
    send(g, pr);
    step(16);
    check("b_guard_out", o_output_idle[5], 1'b0);
    check("b_guard_selv", o_sel_valid[5], 1'b0);
    g = '0; g[6*N + 5] = 1'b1;
    pr = '0; pr[6*P +: P] = 8'h77;
    send(g, pr);
    check("b_err", o_error, 1'b1);
    check("b_sel5", o_sel[5*LOGN +: LOGN], 4'd3);
    check("b_selv", o_sel_valid, '0);
    check("b_in6", o_input_idle, 12'hFFF);
    check("b_out5", o_output_idle, 12'hFFF);

    // Reset in cycle 8 of a transfer aborts it.
    do_reset();
    g = '0; g[2*N + 9] = 1'b1;
    pr = '0; pr[2*P +: P] = 8'h5A;
    e = '0; e.deq = 12'h004; e.outs[2*LOGN +: LOGN] = 4'd9; e.pris[2*P +: P] = 8'h5A;
    exp_q.push_back(e);
    send(g, pr);
    step(7);
    check("r_selv_pre", o_sel_valid, 12'h200);
    reset = 1'b1;
    step();
    check("r_selv", o_sel_valid, '0);
    check("r_sel", o_sel, '0);
    check("r_in", o_input_idle, 12'hFFF);
    check("r_out", o_output_idle, 12'hFFF);
    check("r_deq", o_dequeue, '0);
    check("r_deq_out", o_deq_output, '0);
    check("r_deq_pri", o_deq_priority, '0);
    check("r_err", o_error, 1'b0);
    reset = 1'b0;
    step(20);
    check("r_selv_late", o_sel_valid, '0);

    check("pending_dequeues", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
